// File: rtl/pc_sequencer.sv
// Program counter and control sequencer: start/run/halt FSM, committed ALU flags,
// conditional branch resolution and a circular return-address stack for call/ret.
module pc_sequencer #(
    parameter int PC_W       = 32,
    parameter int IMM_W      = 18,
    parameter int PC_STEP    = 4,
    parameter int START_ADDR = 0,
    parameter int RAS_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             halt_req,
    input  logic             stall,
    input  logic             branch_valid,
    input  logic [2:0]       branch_cond,
    input  logic             call,
    input  logic             ret,
    input  logic [IMM_W-1:0] target,
    input  logic             flags_valid,
    input  logic [1:0]       flags,
    output logic [PC_W-1:0]  pc,
    output logic             pc_valid,
    output logic             flush,
    output logic             end_flag,
    output logic             com_flag,
    output logic             ras_overflow,
    output logic             ras_underflow
);

    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    localparam logic [PC_W-1:0]  START_PC = PC_W'(START_ADDR);
    localparam logic [PC_W-1:0]  STEP_PC  = PC_W'(PC_STEP);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(RAS_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } stateT;

    stateT            state;
    logic [1:0]       flagReg;
    logic [PC_W-1:0]  rasMem [RAS_DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [CNT_W-1:0] rasCount;

    logic [1:0]       effFlags;
    logic             condTaken;
    logic [PC_W-1:0]  seqPc;
    logic [PC_W-1:0]  targetPc;
    logic [PTR_W-1:0] nextPtr;
    logic [PTR_W-1:0] prevPtr;
    logic             pushEn;

    assign seqPc    = pc + STEP_PC;
    assign targetPc = PC_W'(target);
    assign nextPtr  = (wrPtr == LAST_IDX) ? '0 : wrPtr + PTR_W'(1);
    assign prevPtr  = (wrPtr == '0) ? LAST_IDX : wrPtr - PTR_W'(1);
    assign pushEn   = (state == RUN) && !halt_req && !ret && call;

    // A branch issued alongside a flag commit must see the incoming flags, not the stale register.
    always_comb begin
        effFlags  = flags_valid ? flags : flagReg;
        condTaken = 1'b0;
        case (branch_cond)
            3'b000:  condTaken = 1'b1;
            3'b001:  condTaken = effFlags[0];
            3'b010:  condTaken = !effFlags[0];
            3'b011:  condTaken = effFlags[1];
            3'b100:  condTaken = !effFlags[1];
            3'b101:  condTaken = !effFlags[1] && !effFlags[0];
            3'b110:  condTaken = effFlags[1] || effFlags[0];
            default: condTaken = 1'b0;
        endcase
    end

    // Stack storage needs no reset; validity is tracked by rasCount.
    always_ff @(posedge clk) begin
        if (pushEn) begin
            rasMem[wrPtr] <= seqPc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            pc            <= START_PC;
            flagReg       <= 2'b00;
            pc_valid      <= 1'b0;
            flush         <= 1'b0;
            end_flag      <= 1'b0;
            com_flag      <= 1'b0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
            wrPtr         <= '0;
            rasCount      <= '0;
        end else begin
            flush    <= 1'b0;
            com_flag <= flags_valid;
            if (flags_valid) begin
                flagReg <= flags;
            end
            case (state)
                IDLE, HALT: begin
                    if (start) begin
                        state         <= RUN;
                        pc            <= START_PC;
                        pc_valid      <= 1'b1;
                        end_flag      <= 1'b0;
                        wrPtr         <= '0;
                        rasCount      <= '0;
                        ras_overflow  <= 1'b0;
                        ras_underflow <= 1'b0;
                    end
                end
                RUN: begin
                    if (halt_req) begin
                        state    <= HALT;
                        pc_valid <= 1'b0;
                        end_flag <= 1'b1;
                    end else if (ret) begin
                        // Popping an empty stack is fatal to the program: stop with pc held.
                        if (rasCount == '0) begin
                            ras_underflow <= 1'b1;
                            state         <= HALT;
                            pc_valid      <= 1'b0;
                            end_flag      <= 1'b1;
                        end else begin
                            pc       <= rasMem[prevPtr];
                            wrPtr    <= prevPtr;
                            rasCount <= rasCount - CNT_W'(1);
                            flush    <= 1'b1;
                        end
                    end else if (call) begin
                        pc      <= targetPc;
                        flush   <= 1'b1;
                        wrPtr   <= nextPtr;
                        if (rasCount == FULL_CNT) begin
                            ras_overflow <= 1'b1;
                        end else begin
                            rasCount <= rasCount + CNT_W'(1);
                        end
                    end else if (branch_valid && condTaken) begin
                        pc    <= targetPc;
                        flush <= 1'b1;
                    end else if (!stall) begin
                        pc <= seqPc;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
